// File: rtl/divu_arbiter.sv
// Round-robin front end sharing one multi-cycle unsigned divider among NREQ requesters.
// Define DIVU_ARB_TIMEOUT_EN to add a watchdog on the divider start/busy handshake.
module divu_arbiter #(
    parameter int WIDTH   = 8,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [NREQ-1:0]           req_valid_i,
    input  logic [NREQ*WIDTH-1:0]     req_a_i,
    input  logic [NREQ*(WIDTH/2)-1:0] req_b_i,
    output logic [NREQ-1:0]           req_ready_o,
    output logic [NREQ-1:0]           resp_valid_o,
    output logic [WIDTH-1:0]          resp_q_o,
    output logic [WIDTH-1:0]          resp_r_o,
    output logic                      resp_err_o,
    output logic                      busy_o,
    output logic [WIDTH-1:0]          div_a_o,
    output logic [WIDTH/2-1:0]        div_b_o,
    output logic                      div_start_o,
    input  logic                      div_busy_i,
    input  logic [WIDTH-1:0]          div_q_i,
    input  logic [WIDTH-1:0]          div_r_i
);
    // state     | meaning
    // IDLE      | arbitrating, ready offered to the round-robin winner
    // ISSUE     | one-cycle start pulse to the divider
    // WAIT_BUSY | waiting for the divider to raise busy
    // WAIT_DONE | waiting for busy to fall, then capture the result
    // RESP      | one-cycle response pulse to the granted requester
    localparam int HW  = WIDTH / 2;
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;
    state_t state_q, state_d;

    logic [IDW-1:0]   ptr_q, ptr_d, gnt_q, gnt_d, win;
    logic [IDW:0]     sum;
    logic             found, accept, tmo_hit;
    logic [WIDTH-1:0] div_a_q, div_a_d, resp_q_q, resp_q_d, resp_r_q, resp_r_d;
    logic [HW-1:0]    div_b_q, div_b_d;
    logic             resp_err_q, resp_err_d, busy_q, busy_d;

    logic [WIDTH-1:0] a_arr [NREQ];
    logic [HW-1:0]    b_arr [NREQ];
    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign a_arr[i] = req_a_i[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b_i[i*HW +: HW];
    end

    // Search starts at the pointer and wraps, so the first valid hit is the winner.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
            if (!found && req_valid_i[sum[IDW-1:0]]) begin
                found = 1'b1;
                win   = sum[IDW-1:0];
            end
        end
    end

    assign accept = (state_q == IDLE) && found && !reset_i;

`ifdef DIVU_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        tmo_d = tmo_q;
        if (state_q == ISSUE)
            tmo_d = TW'(TIMEOUT - 1);
        else if ((state_q == WAIT_BUSY || state_q == WAIT_DONE) && tmo_q != '0)
            tmo_d = tmo_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) tmo_q <= '0;
        else         tmo_q <= tmo_d;
    end

    assign tmo_hit = (state_q == WAIT_BUSY || state_q == WAIT_DONE) && (tmo_q == '0);
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT != 0);
    assign tmo_hit        = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = (b_arr[win] == '0) ? RESP : ISSUE;
            ISSUE:     state_d = WAIT_BUSY;
            WAIT_BUSY: if (div_busy_i) state_d = WAIT_DONE;
                       else if (tmo_hit) state_d = RESP;
            WAIT_DONE: if (!div_busy_i || tmo_hit) state_d = RESP;
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        div_start_o  = 1'b0;
        if (!reset_i) begin
            if (accept) req_ready_o[win] = 1'b1;
            if (state_q == RESP) resp_valid_o[gnt_q] = 1'b1;
            if (state_q == ISSUE) div_start_o = 1'b1;
        end
    end

    always_comb begin
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        div_a_d    = div_a_q;
        div_b_d    = div_b_q;
        resp_q_d   = resp_q_q;
        resp_r_d   = resp_r_q;
        resp_err_d = resp_err_q;
        busy_d     = busy_q;
        case (state_q)
            IDLE: if (accept) begin
                ptr_d   = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
                gnt_d   = win;
                div_a_d = a_arr[win];
                div_b_d = b_arr[win];
                busy_d  = 1'b1;
                // Divide-by-zero answers directly without ever starting the divider.
                if (b_arr[win] == '0) begin
                    resp_q_d   = '1;
                    resp_r_d   = a_arr[win];
                    resp_err_d = 1'b1;
                end
            end
            WAIT_BUSY: if (!div_busy_i && tmo_hit) begin
                resp_q_d   = '0;
                resp_r_d   = '0;
                resp_err_d = 1'b1;
            end
            WAIT_DONE: if (!div_busy_i) begin
                resp_q_d   = div_q_i;
                resp_r_d   = div_r_i;
                resp_err_d = 1'b0;
            end else if (tmo_hit) begin
                resp_q_d   = '0;
                resp_r_d   = '0;
                resp_err_d = 1'b1;
            end
            RESP: busy_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q      <= '0;
            gnt_q      <= '0;
            div_a_q    <= '0;
            div_b_q    <= '0;
            resp_q_q   <= '0;
            resp_r_q   <= '0;
            resp_err_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            div_a_q    <= div_a_d;
            div_b_q    <= div_b_d;
            resp_q_q   <= resp_q_d;
            resp_r_q   <= resp_r_d;
            resp_err_q <= resp_err_d;
            busy_q     <= busy_d;
        end
    end

    assign div_a_o    = div_a_q;
    assign div_b_o    = div_b_q;
    assign resp_q_o   = resp_q_q;
    assign resp_r_o   = resp_r_q;
    assign resp_err_o = resp_err_q;
    assign busy_o     = busy_q;
endmodule

// File: tb/tb_divu_arbiter.sv
// Directed bench for divu_arbiter: behavioural divider with adjustable busy length,
// a negedge monitor logging grants/responses, and one task per scenario.
module tb_divu_arbiter;
    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int HW    = 4;
`ifdef DIVU_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic [NREQ-1:0]  req_valid;
    logic [31:0]      req_a;
    logic [15:0]      req_b;
    logic [NREQ-1:0]  req_ready, resp_valid;
    logic [7:0]       resp_q, resp_r, div_a, div_q, div_r;
    logic [3:0]       div_b;
    logic             resp_err, busy, div_start, div_busy;

    divu_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
        .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_q_o(resp_q), .resp_r_o(resp_r),
        .resp_err_o(resp_err), .busy_o(busy), .div_a_o(div_a), .div_b_o(div_b),
        .div_start_o(div_start), .div_busy_i(div_busy), .div_q_i(div_q), .div_r_i(div_r)
    );

    // Divider model: busy for 'dur' cycles after start; 'stuck' forces busy high.
    int   dur   = 1;
    bit   stuck = 1'b0;
    int   m_cnt;
    logic m_busy;
    always @(posedge clk) begin
        if (reset) begin
            m_cnt <= 0; m_busy <= 1'b0; div_q <= '0; div_r <= '0;
        end else if (div_start) begin
            m_cnt <= dur; m_busy <= 1'b1;
        end else if (m_cnt > 1) begin
            m_cnt <= m_cnt - 1;
        end else if (m_cnt == 1) begin
            m_cnt <= 0; m_busy <= 1'b0;
            div_q <= div_a / {4'b0, div_b};
            div_r <= div_a % {4'b0, div_b};
        end
    end
    assign div_busy = m_busy | stuck;

    int         cyc_n = 0, n_start = 0, n_multi = 0;
    int         n_rdy [NREQ];
    int         acc_id[$], acc_cyc[$], rsp_cyc[$];
    logic [3:0] rsp_vec[$];
    logic [7:0] rsp_q[$], rsp_r[$];
    logic       rsp_err[$];

    always @(negedge clk) begin
        cyc_n++;
        if (div_start === 1'b1) n_start++;
        if ($countones(req_ready) > 1) n_multi++;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i] === 1'b1) n_rdy[i]++;
            if (req_valid[i] && req_ready[i] === 1'b1) begin
                acc_id.push_back(i); acc_cyc.push_back(cyc_n);
            end
        end
        if (resp_valid !== 4'b0) begin
            rsp_vec.push_back(resp_valid); rsp_q.push_back(resp_q); rsp_r.push_back(resp_r);
            rsp_err.push_back(resp_err); rsp_cyc.push_back(cyc_n);
        end
    end

    int n_pass = 0, n_chk = 0;

    task automatic drive_edge(); @(posedge clk); #1; endtask
    task automatic sample_edge(); @(negedge clk); #1; endtask

    task automatic set_op(input int i, input logic [7:0] a, input logic [3:0] b);
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*HW +: HW]       = b;
    endtask

    // Releases each requester once accepted (unless in hold); returns after nresp responses.
    task automatic run(input logic [3:0] hold, input int nresp, input int max_cyc, output bit ok);
        int         r0   = rsp_vec.size();
        logic [3:0] drop = '0;
        ok = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            sample_edge();
            drop = req_valid & req_ready & ~hold;
            if (rsp_vec.size() - r0 >= nresp) begin ok = 1'b1; break; end
            drive_edge();
            req_valid = req_valid & ~drop;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 4'b1111; req_a = 32'h1122_3344; req_b = 16'h1234;
        repeat (3) sample_edge();
        n_chk++; if (req_ready !== 4'b0)  $display("FAIL rst_ready got=%b exp=0000", req_ready);  else n_pass++;
        n_chk++; if (resp_valid !== 4'b0) $display("FAIL rst_resp_valid got=%b exp=0000", resp_valid); else n_pass++;
        n_chk++; if (busy !== 1'b0)       $display("FAIL rst_busy got=%b exp=0", busy); else n_pass++;
        n_chk++; if (div_start !== 1'b0)  $display("FAIL rst_div_start got=%b exp=0", div_start); else n_pass++;
        n_chk++; if (div_a !== 8'd0 || div_b !== 4'd0) $display("FAIL rst_div_ops got=%0d/%0d exp=0/0", div_a, div_b); else n_pass++;
        n_chk++; if (resp_q !== 8'd0 || resp_r !== 8'd0 || resp_err !== 1'b0)
            $display("FAIL rst_resp got=%0d/%0d/%b exp=0/0/0", resp_q, resp_r, resp_err); else n_pass++;
        drive_edge(); req_valid = '0; reset = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int s_acc = acc_id.size(), s_st = n_start, s_rsp = rsp_vec.size();
        drive_edge(); dur = 1; set_op(1, 8'd100, 4'd7); req_valid = 4'b0010;
        run(4'b0000, 1, 30, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL single_resp_seen got=%b exp=1", ok); else n_pass++;
        if (ok) begin
            n_chk++; if (acc_id.size() - s_acc !== 1 || acc_id[s_acc] !== 1)
                $display("FAIL single_accept got_n=%0d exp_n=1", acc_id.size() - s_acc); else n_pass++;
            n_chk++; if (n_start - s_st !== 1) $display("FAIL single_starts got=%0d exp=1", n_start - s_st); else n_pass++;
            n_chk++; if (rsp_vec[s_rsp] !== 4'b0010) $display("FAIL single_vec got=%b exp=0010", rsp_vec[s_rsp]); else n_pass++;
            n_chk++; if (rsp_q[s_rsp] !== 8'd14 || rsp_r[s_rsp] !== 8'd2 || rsp_err[s_rsp] !== 1'b0)
                $display("FAIL single_result got=%0d r%0d e%b exp=14 r2 e0", rsp_q[s_rsp], rsp_r[s_rsp], rsp_err[s_rsp]); else n_pass++;
            n_chk++; if (rsp_cyc[s_rsp] - acc_cyc[s_acc] !== 4)
                $display("FAIL single_latency got=%0d exp=4", rsp_cyc[s_rsp] - acc_cyc[s_acc]); else n_pass++;
            n_chk++; if (busy !== 1'b1) $display("FAIL single_busy_in_resp got=%b exp=1", busy); else n_pass++;
        end
        drive_edge(); sample_edge();
        n_chk++; if (busy !== 1'b0 || resp_valid !== 4'b0)
            $display("FAIL single_after got_busy=%b got_vec=%b exp=0/0000", busy, resp_valid); else n_pass++;
    endtask

    task automatic test_div_zero();
        bit ok;
        int s_acc = acc_id.size(), s_st = n_start, s_rsp = rsp_vec.size();
        drive_edge(); set_op(2, 8'd55, 4'd0); req_valid = 4'b0100;
        run(4'b0000, 1, 30, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL dz_resp_seen got=%b exp=1", ok); else n_pass++;
        if (ok) begin
            n_chk++; if (n_start - s_st !== 0) $display("FAIL dz_starts got=%0d exp=0", n_start - s_st); else n_pass++;
            n_chk++; if (rsp_vec[s_rsp] !== 4'b0100) $display("FAIL dz_vec got=%b exp=0100", rsp_vec[s_rsp]); else n_pass++;
            n_chk++; if (rsp_q[s_rsp] !== 8'd255 || rsp_r[s_rsp] !== 8'd55 || rsp_err[s_rsp] !== 1'b1)
                $display("FAIL dz_result got=%0d r%0d e%b exp=255 r55 e1", rsp_q[s_rsp], rsp_r[s_rsp], rsp_err[s_rsp]); else n_pass++;
            n_chk++; if (rsp_cyc[s_rsp] - acc_cyc[s_acc] !== 1)
                $display("FAIL dz_latency got=%0d exp=1", rsp_cyc[s_rsp] - acc_cyc[s_acc]); else n_pass++;
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int eq[4] = '{66, 50, 33, 5};
        int er[4] = '{2, 0, 0, 2};
        int s_acc, s_rsp;
        drive_edge(); reset = 1'b1; req_valid = 4'b1111;
        set_op(0, 8'd200, 4'd3); set_op(1, 8'd150, 4'd3); set_op(2, 8'd99, 4'd3); set_op(3, 8'd17, 4'd3);
        sample_edge();
        n_chk++; if (req_ready !== 4'b0) $display("FAIL rr_ready_in_reset got=%b exp=0000", req_ready); else n_pass++;
        drive_edge(); reset = 1'b0;
        s_acc = acc_id.size(); s_rsp = rsp_vec.size();
        run(4'b0000, 4, 80, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL rr4_resp_seen got=%b exp=1", ok); else n_pass++;
        if (ok) begin
            for (int i = 0; i < 4; i++) begin
                n_chk++; if (acc_id[s_acc+i] !== i) $display("FAIL rr4_order slot%0d got=%0d exp=%0d", i, acc_id[s_acc+i], i); else n_pass++;
                n_chk++; if (rsp_vec[s_rsp+i] !== 4'(1 << i) || rsp_q[s_rsp+i] !== 8'(eq[i]) || rsp_r[s_rsp+i] !== 8'(er[i]))
                    $display("FAIL rr4_result slot%0d got=%b q%0d r%0d exp q%0d r%0d", i, rsp_vec[s_rsp+i],
                             rsp_q[s_rsp+i], rsp_r[s_rsp+i], eq[i], er[i]); else n_pass++;
            end
        end
        drive_edge(); req_valid = '0; set_op(0, 8'd10, 4'd3); set_op(2, 8'd20, 4'd6); req_valid = 4'b0101;
        s_acc = acc_id.size(); s_rsp = rsp_vec.size();
        run(4'b0000, 2, 40, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL rr2_resp_seen got=%b exp=1", ok); else n_pass++;
        if (ok) begin
            n_chk++; if (acc_id[s_acc] !== 0 || acc_id[s_acc+1] !== 2)
                $display("FAIL rr2_order got=%0d,%0d exp=0,2", acc_id[s_acc], acc_id[s_acc+1]); else n_pass++;
            n_chk++; if (rsp_q[s_rsp] !== 8'd3 || rsp_r[s_rsp] !== 8'd1 || rsp_q[s_rsp+1] !== 8'd3 || rsp_r[s_rsp+1] !== 8'd2)
                $display("FAIL rr2_result got=%0d r%0d,%0d r%0d exp=3 r1,3 r2", rsp_q[s_rsp], rsp_r[s_rsp],
                         rsp_q[s_rsp+1], rsp_r[s_rsp+1]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int s_acc = acc_id.size(), s_rsp = rsp_vec.size(), s_rdy = n_rdy[3], s_multi = n_multi;
        drive_edge(); set_op(3, 8'd9, 4'd2); req_valid = 4'b1000;
        run(4'b1000, 2, 40, ok);
        drive_edge(); req_valid = '0;
        n_chk++; if (ok !== 1'b1) $display("FAIL b2b_resp_seen got=%b exp=1", ok); else n_pass++;
        if (ok) begin
            n_chk++; if (acc_id.size() - s_acc !== 2 || acc_id[s_acc] !== 3 || acc_id[s_acc+1] !== 3)
                $display("FAIL b2b_accepts got_n=%0d exp_n=2", acc_id.size() - s_acc); else n_pass++;
            n_chk++; if (n_rdy[3] - s_rdy !== 2) $display("FAIL b2b_ready_cycles got=%0d exp=2", n_rdy[3] - s_rdy); else n_pass++;
            n_chk++; if (acc_cyc[s_acc+1] - acc_cyc[s_acc] !== 5)
                $display("FAIL b2b_spacing got=%0d exp=5", acc_cyc[s_acc+1] - acc_cyc[s_acc]); else n_pass++;
            n_chk++; if (rsp_q[s_rsp+1] !== 8'd4 || rsp_r[s_rsp+1] !== 8'd1 || rsp_vec[s_rsp+1] !== 4'b1000)
                $display("FAIL b2b_result got=%0d r%0d v%b exp=4 r1 v1000", rsp_q[s_rsp+1], rsp_r[s_rsp+1], rsp_vec[s_rsp+1]); else n_pass++;
        end
        n_chk++; if (n_multi - s_multi !== 0) $display("FAIL b2b_onehot got=%0d exp=0", n_multi - s_multi); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        int s_st = n_start, s_rsp = rsp_vec.size(), s_acc;
        drive_edge(); dur = 5; set_op(1, 8'd100, 4'd7); req_valid = 4'b0010;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            sample_edge();
            seen = (req_valid & req_ready) != 4'b0;
        end
        n_chk++; if (seen !== 1'b1) $display("FAIL mid_accept got=%b exp=1", seen); else n_pass++;
        drive_edge(); req_valid = '0;
        drive_edge();
        drive_edge(); reset = 1'b1;
        sample_edge();
        n_chk++; if (div_start !== 1'b0 || resp_valid !== 4'b0 || req_ready !== 4'b0)
            $display("FAIL mid_in_reset got=%b/%b/%b exp=0/0000/0000", div_start, resp_valid, req_ready); else n_pass++;
        drive_edge(); reset = 1'b0;
        sample_edge();
        n_chk++; if (busy !== 1'b0) $display("FAIL mid_busy got=%b exp=0", busy); else n_pass++;
        repeat (12) sample_edge();
        n_chk++; if (rsp_vec.size() - s_rsp !== 0) $display("FAIL mid_lost_resp got=%0d exp=0", rsp_vec.size() - s_rsp); else n_pass++;
        n_chk++; if (n_start - s_st !== 1) $display("FAIL mid_starts got=%0d exp=1", n_start - s_st); else n_pass++;
        drive_edge(); dur = 1; set_op(0, 8'd9, 4'd4); set_op(2, 8'd8, 4'd4); req_valid = 4'b0101;
        s_acc = acc_id.size(); s_rsp = rsp_vec.size();
        run(4'b0000, 2, 40, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL mid_fresh_seen got=%b exp=1", ok); else n_pass++;
        if (ok) begin
            n_chk++; if (acc_id[s_acc] !== 0) $display("FAIL mid_pointer got=%0d exp=0", acc_id[s_acc]); else n_pass++;
            n_chk++; if (rsp_vec[s_rsp] !== 4'b0001 || rsp_q[s_rsp] !== 8'd2 || rsp_r[s_rsp] !== 8'd1 || rsp_err[s_rsp] !== 1'b0)
                $display("FAIL mid_fresh_result got=%b q%0d r%0d exp=0001 q2 r1", rsp_vec[s_rsp], rsp_q[s_rsp], rsp_r[s_rsp]); else n_pass++;
        end
    endtask

    task automatic test_busy_glitch();
        int s_st = n_start, s_rsp = rsp_vec.size();
        drive_edge(); stuck = 1'b1;
        sample_edge();
        drive_edge(); stuck = 1'b0;
        sample_edge();
        n_chk++; if (busy !== 1'b0 || n_start - s_st !== 0 || rsp_vec.size() - s_rsp !== 0)
            $display("FAIL glitch got_busy=%b starts=%0d resps=%0d exp=0/0/0", busy, n_start - s_st, rsp_vec.size() - s_rsp); else n_pass++;
    endtask

    task automatic test_timeout();
        bit ok;
        int s_acc = acc_id.size(), s_rsp = rsp_vec.size();
        drive_edge(); dur = 1; stuck = 1'b1; set_op(0, 8'd50, 4'd5); req_valid = 4'b0001;
`ifdef DIVU_ARB_TIMEOUT_EN
        run(4'b0000, 1, 40, ok);
        stuck = 1'b0;
        n_chk++; if (ok !== 1'b1) $display("FAIL tmo_resp_seen got=%b exp=1", ok); else n_pass++;
        if (ok) begin
            n_chk++; if (rsp_vec[s_rsp] !== 4'b0001 || rsp_q[s_rsp] !== 8'd0 || rsp_r[s_rsp] !== 8'd0 || rsp_err[s_rsp] !== 1'b1)
                $display("FAIL tmo_result got=%b q%0d r%0d e%b exp=0001 q0 r0 e1", rsp_vec[s_rsp], rsp_q[s_rsp], rsp_r[s_rsp], rsp_err[s_rsp]); else n_pass++;
            n_chk++; if (rsp_cyc[s_rsp] - acc_cyc[s_acc] !== 10)
                $display("FAIL tmo_latency got=%0d exp=10", rsp_cyc[s_rsp] - acc_cyc[s_acc]); else n_pass++;
        end
`else
        run(4'b0000, 1, 100, ok);
        n_chk++; if (ok !== 1'b0 || busy !== 1'b1) $display("FAIL hang_no_resp got_resp=%b busy=%b exp=0/1", ok, busy); else n_pass++;
        drive_edge(); stuck = 1'b0;
        run(4'b0000, 1, 20, ok);
        n_chk++; if (ok !== 1'b1) $display("FAIL hang_release_seen got=%b exp=1", ok); else n_pass++;
        if (ok) begin
            n_chk++; if (acc_id[s_acc] !== 0 || rsp_q[s_rsp] !== 8'd10 || rsp_r[s_rsp] !== 8'd0 || rsp_err[s_rsp] !== 1'b0)
                $display("FAIL hang_result got=q%0d r%0d e%b exp=q10 r0 e0", rsp_q[s_rsp], rsp_r[s_rsp], rsp_err[s_rsp]); else n_pass++;
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_div_zero();
        test_round_robin();
        test_back_to_back();
        test_reset_mid();
        test_busy_glitch();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d passed=%0d", n_chk, n_pass);
        $fatal(1);
    end
endmodule
